mp_multdiv_iter: RTL and testbench
==================================

Name: mp_multdiv_iter

Overview:
- Parametrised iterative multiply/divide unit. It succeeds the single-width slow multdiv in the extended core.
- Supports MUL/MULH(SU/U)/DIV(U)/REM(U) at any WIDTH and retires STEPS bits per cycle.
- Has its own adder, so it does not share the ALU. It sits beside the core's ALU in EX, or in the mixed-precision accelerator lanes, behind a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; ≥ 4 and even.
- STEPS, 1, shift-add or restoring-subtract steps per cycle; must divide WIDTH (1, 2 or 4).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  operation request; accepted when req_i && ready_o.
- operator_i  in  2  0 MUL, 1 MULH, 2 DIV, 3 REM; sampled at accept.
- signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed; sampled at accept.
- op_a_i  in  WIDTH  multiplicand or dividend.
- op_b_i  in  WIDTH  multiplier or divisor.
- data_ind_timing_i  in  1  1 forces fixed latency; sampled at accept.
- kill_i  in  1  abort the operation in flight.
- ack_i  in  1  consumer takes the result.
- ready_o  out  1  unit idle and able to accept.
- valid_o  out  1  result_o valid.
- result_o  out  WIDTH  result.

Behaviour:
- Reset values: ready_o=1, valid_o=0, result_o=0. Reset also clears state to IDLE and clears all datapath registers. An asserted reset aborts any operation immediately; there is no valid_o afterwards.
- States: IDLE, ITER, FIX, DONE.
- IDLE
  - ready_o=1.
  - On accept, register the operator and mode. Latch sign_a = op_a[W-1]&mode[0] and sign_b = op_b[W-1]&mode[1].
  - Latch |op_a| and |op_b| as unsigned WIDTH-bit magnitudes. |MIN| = 2^(W-1) is valid.
  - Clear accumulator and counter, set count = WIDTH/STEPS. Next state is ITER.
- ITER, one cycle per iteration, STEPS sub-steps chained combinationally:
  - Multiply: 2W-bit magnitude product via LSB-first shift-add.
  - Divide: restoring division, MSB-first. Quotient and remainder are WIDTH bits each.
  - count decrements every cycle; count==1 means next state FIX.
- FIX, one cycle: sign correction by two's-complement negate.
  - MUL: low WIDTH bits of the product, negated if sign_a^sign_b.
  - MULH: high WIDTH bits of the 2W product, negated as a 2W value if sign_a^sign_b.
  - DIV: quotient, negated if sign_a^sign_b and divisor ≠ 0.
  - REM: remainder, negated if sign_a.
  - Next state DONE.
- DONE
  - valid_o=1 and result_o is held stable until ack_i. On ack_i, next state IDLE.
  - ready_o=0 in DONE, so a req_i in the same cycle as ack_i is not accepted. It is accepted the following cycle.
- Latency without early-out: accept cycle T gives valid_o at T+WIDTH/STEPS+2.
- Divide by zero: quotient all-ones, remainder = op_a (no sign flip). Both fall out of the restoring algorithm plus the FIX rules above.
- Overflow (signed MIN / -1): quotient MIN, remainder 0.
- kill_i: from any state the next state is IDLE and valid_o deasserts. kill_i outranks a simultaneous req_i and ack_i.
- Inputs are not required stable after accept.

Optional Feature:
- Macro MP_MULTDIV_EARLY_OUT_EN.
- Defined, early-out applies when the latched data_ind_timing_i=0:
  - MUL/MULH: at the end of any ITER cycle, if the remaining multiplier bits are all zero, go to FIX.
  - DIV/REM: a zero divisor at accept skips ITER, IDLE→FIX, and loads the div-by-zero results.
- Not defined: data_ind_timing_i is ignored and latency is always fixed.

Test Plan:
- WIDTH=32, STEPS=1; MUL 0x7 × 0xFFFFFFFD signed (11): accept at T → valid_o at T+34, result 0xFFFFFFEB; held 3 cycles until ack_i.
- MULH signed 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV signed 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0; DIV -7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF.
- Divide by zero, DIV 5/0 → 0xFFFFFFFF, REM -5/0 → 0xFFFFFFFB.
  - With MP_MULTDIV_EARLY_OUT_EN and data_ind_timing_i=0: valid at T+2.
  - Otherwise: valid at T+34.
- kill_i at T+10 of a DIV → valid_o never rises, ready_o=1 at T+11. rst_ni pulse mid-ITER → IDLE, all outputs at reset values.
- WIDTH=16, STEPS=4: MUL 0x1234 × 0x0010 → 0x2340, valid at T+6. With the macro and data_ind_timing_i=0: valid at T+4.

Source files
------------

// File: rtl/mp_multdiv_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master side issues operations and acknowledges results; the slave side
// is the unit itself.
interface mp_multdiv_iter_if #(
   parameter int WIDTH = 32
) ();
   logic             req_i;
   logic [1:0]       operator_i;
   logic [1:0]       signed_mode_i;
   logic [WIDTH-1:0] op_a_i;
   logic [WIDTH-1:0] op_b_i;
   logic             data_ind_timing_i;
   logic             kill_i;
   logic             ack_i;
   logic             ready_o;
   logic             valid_o;
   logic [WIDTH-1:0] result_o;

   modport master (
      output req_i, operator_i, signed_mode_i, op_a_i, op_b_i,
             data_ind_timing_i, kill_i, ack_i,
      input  ready_o, valid_o, result_o
   );

   modport slave (
      input  req_i, operator_i, signed_mode_i, op_a_i, op_b_i,
             data_ind_timing_i, kill_i, ack_i,
      output ready_o, valid_o, result_o
   );
endinterface

// File: rtl/mp_multdiv_iter.sv
// Iterative multiply/divide unit: MUL, MULH(SU/U), DIV(U), REM(U) on WIDTH-bit
// operands, retiring STEPS bits per cycle with its own adder. Operands are
// reduced to magnitudes on accept, iterated as unsigned, and sign-corrected in
// a single FIX cycle.
// Optional early-out (macro MP_MULTDIV_EARLY_OUT_EN): when the latched
// data_ind_timing_i is 0, multiplies stop once the remaining multiplier bits
// are zero and divides by zero skip iteration entirely.
module mp_multdiv_iter #(
   parameter int WIDTH = 32,
   parameter int STEPS = 1
) (
   input logic              clk_i,
   input logic              rst_ni,
   mp_multdiv_iter_if.slave bus
);

   localparam int NITER = WIDTH / STEPS;
   localparam int CW    = $clog2(NITER + 1);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or {remainder, quotient}
   logic [2*WIDTH-1:0] opa_q, opa_d;       // shifted multiplicand / dividend
   logic [WIDTH-1:0]   opb_q, opb_d;       // shifted multiplier / divisor
   logic [WIDTH-1:0]   result_q, result_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic               accept;
   logic               a_sign, b_sign;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] it_acc, it_opa;
   logic [WIDTH-1:0]   it_opb;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   diff;
   logic [2*WIDTH-1:0] prod_n;
   logic [WIDTH-1:0]   fix_res;
   logic               eo_dz, eo_mul;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                    input logic neg);
      return neg ? -v : v;
   endfunction

   assign accept = bus.req_i && (state_q == IDLE) && !bus.kill_i;
   assign a_sign = bus.op_a_i[WIDTH-1] & bus.signed_mode_i[0];
   assign b_sign = bus.op_b_i[WIDTH-1] & bus.signed_mode_i[1];
   assign mag_a  = cond_neg(bus.op_a_i, a_sign);
   assign mag_b  = cond_neg(bus.op_b_i, b_sign);

`ifdef MP_MULTDIV_EARLY_OUT_EN
   logic dit_q, dit_d;

   assign dit_d  = accept ? bus.data_ind_timing_i : dit_q;
   assign eo_dz  = !bus.data_ind_timing_i && bus.operator_i[1] && (bus.op_b_i == '0);
   assign eo_mul = !dit_q && !op_q[1] && (it_opb == '0);

   // Latch the timing mode for the whole operation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) dit_q <= 1'b0;
      else         dit_q <= dit_d;
   end
`else
   logic unused_dit;

   assign unused_dit = bus.data_ind_timing_i;
   assign eo_dz      = 1'b0;
   assign eo_mul     = 1'b0;
`endif

   // One iteration: STEPS shift-add (multiply, LSB first) or restoring
   // subtract (divide, MSB first) sub-steps chained combinationally.
   always_comb begin
      it_acc = acc_q;
      it_opa = opa_q;
      it_opb = opb_q;
      rem_sh = '0;
      diff   = '0;
      for (int s = 0; s < STEPS; s++) begin
         if (op_q[1]) begin
            rem_sh = {it_acc[2*WIDTH-1:WIDTH], it_opa[WIDTH-1]};
            diff   = {1'b0, rem_sh} - {2'b00, opb_q};
            it_opa = it_opa << 1;
            if (!diff[WIDTH+1]) it_acc = {diff[WIDTH-1:0], it_acc[WIDTH-2:0], 1'b1};
            else                it_acc = {rem_sh[WIDTH-1:0], it_acc[WIDTH-2:0], 1'b0};
         end else begin
            if (it_opb[0]) it_acc = it_acc + it_opa;
            it_opa = it_opa << 1;
            it_opb = it_opb >> 1;
         end
      end
   end

   // Sign correction of the magnitude result. A zero divisor keeps the
   // all-ones quotient; the remainder follows the dividend sign only.
   always_comb begin
      prod_n = cond_neg2(acc_q, sign_a_q ^ sign_b_q);
      case (op_q)
         2'd0:    fix_res = prod_n[WIDTH-1:0];
         2'd1:    fix_res = prod_n[2*WIDTH-1:WIDTH];
         2'd2:    fix_res = cond_neg(acc_q[WIDTH-1:0],
                                     (sign_a_q ^ sign_b_q) && (opb_q != '0));
         default: fix_res = cond_neg(acc_q[2*WIDTH-1:WIDTH], sign_a_q);
      endcase
   end

   // Datapath next-state: load on accept, iterate in ITER, capture in FIX.
   always_comb begin
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d     = bus.operator_i;
               sign_a_d = a_sign;
               sign_b_d = b_sign;
               opa_d    = {{WIDTH{1'b0}}, mag_a};
               opb_d    = mag_b;
               acc_d    = eo_dz ? {mag_a, {WIDTH{1'b1}}} : '0;
               cnt_d    = CW'(NITER);
            end
         end
         ITER: begin
            acc_d = it_acc;
            opa_d = it_opa;
            opb_d = it_opb;
            cnt_d = cnt_q - CW'(1);
         end
         FIX:     result_d = fix_res;
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         acc_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         acc_q    <= acc_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // FSM next state; kill overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.req_i) state_d = eo_dz ? FIX : ITER;
         ITER: if ((cnt_q == CW'(1)) || eo_mul) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: if (bus.ack_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.kill_i) state_d = IDLE;
   end

   // FSM outputs.
   always_comb begin
      bus.ready_o  = (state_q == IDLE);
      bus.valid_o  = (state_q == DONE);
      bus.result_o = result_q;
   end

endmodule

// File: tb/tb_mp_multdiv_iter.sv
// Directed bench for mp_multdiv_iter: a WIDTH=32/STEPS=1 instance and a
// WIDTH=16/STEPS=4 instance, hand-computed results and latencies.
module tb_mp_multdiv_iter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

`ifdef MP_MULTDIV_EARLY_OUT_EN
   localparam int LAT_DZ  = 2;
   localparam int LAT16_E = 4;
`else
   localparam int LAT_DZ  = 34;
   localparam int LAT16_E = 6;
`endif

   mp_multdiv_iter_if #(.WIDTH(32)) if32 ();
   mp_multdiv_iter_if #(.WIDTH(16)) if16 ();

   mp_multdiv_iter #(.WIDTH(32), .STEPS(1)) dut32 (
      .clk_i (clk), .rst_ni(rst_n), .bus(if32.slave));
   mp_multdiv_iter #(.WIDTH(16), .STEPS(4)) dut16 (
      .clk_i (clk), .rst_ni(rst_n), .bus(if16.slave));

   initial begin
      #200000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      if32.req_i = 0; if32.operator_i = 0; if32.signed_mode_i = 0;
      if32.op_a_i = 0; if32.op_b_i = 0; if32.data_ind_timing_i = 0;
      if32.kill_i = 0; if32.ack_i = 0;
      if16.req_i = 0; if16.operator_i = 0; if16.signed_mode_i = 0;
      if16.op_a_i = 0; if16.op_b_i = 0; if16.data_ind_timing_i = 0;
      if16.kill_i = 0; if16.ack_i = 0;
   endtask

   task automatic do32(input logic [1:0] op, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b, input logic dit,
                       output int lat, output logic [31:0] res);
      @(negedge clk);
      if32.req_i = 1; if32.operator_i = op; if32.signed_mode_i = mode;
      if32.op_a_i = a; if32.op_b_i = b; if32.data_ind_timing_i = dit;
      @(posedge clk); #1;
      if32.req_i = 0; if32.op_a_i = 32'hDEADBEEF; if32.op_b_i = 0;
      if32.operator_i = ~op; if32.signed_mode_i = ~mode; if32.data_ind_timing_i = ~dit;
      lat = 1;
      while (!if32.valid_o && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      res = if32.result_o;
   endtask

   task automatic ack32();
      @(negedge clk); if32.ack_i = 1;
      @(posedge clk); #1; if32.ack_i = 0;
   endtask

   task automatic do16(input logic [1:0] op, input logic [1:0] mode,
                       input logic [15:0] a, input logic [15:0] b, input logic dit,
                       output int lat, output logic [15:0] res);
      @(negedge clk);
      if16.req_i = 1; if16.operator_i = op; if16.signed_mode_i = mode;
      if16.op_a_i = a; if16.op_b_i = b; if16.data_ind_timing_i = dit;
      @(posedge clk); #1;
      if16.req_i = 0; if16.op_a_i = 16'hBEEF; if16.op_b_i = 0;
      lat = 1;
      while (!if16.valid_o && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      res = if16.result_o;
      @(negedge clk); if16.ack_i = 1;
      @(posedge clk); #1; if16.ack_i = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (if32.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready32 got %b want 1", if32.ready_o); end
      checks++; if (if32.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid32 got %b want 0", if32.valid_o); end
      checks++; if (if32.result_o !== 32'h0) begin errors++; $display("FAIL reset_result32 got %h want 0", if32.result_o); end
      checks++; if (if16.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready16 got %b want 1", if16.ready_o); end
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_mul();
      int lat; logic [31:0] res;
      do32(2'd0, 2'b11, 32'h7, 32'hFFFFFFFD, 1'b1, lat, res);
      checks++; if (lat != 34) begin errors++; $display("FAIL mul_latency got %0d want 34", lat); end
      checks++; if (res !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", res); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (if32.valid_o !== 1'b1) begin errors++; $display("FAIL mul_hold_valid cycle %0d got %b want 1", i, if32.valid_o); end
         checks++; if (if32.result_o !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_hold_result cycle %0d got %h want ffffffeb", i, if32.result_o); end
      end
      ack32();
      checks++; if (if32.valid_o !== 1'b0) begin errors++; $display("FAIL mul_after_ack_valid got %b want 0", if32.valid_o); end
      checks++; if (if32.ready_o !== 1'b1) begin errors++; $display("FAIL mul_after_ack_ready got %b want 1", if32.ready_o); end
   endtask

   task automatic test_mulh();
      int lat; logic [31:0] res;
      do32(2'd1, 2'b11, 32'h80000000, 32'h80000000, 1'b1, lat, res); ack32();
      checks++; if (res !== 32'h40000000) begin errors++; $display("FAIL mulh_ss got %h want 40000000", res); end
      do32(2'd1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, res); ack32();
      checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulh_uu got %h want fffffffe", res); end
      do32(2'd1, 2'b01, 32'hFFFFFFFF, 32'h2, 1'b0, lat, res); ack32();
      checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulh_su got %h want ffffffff", res); end
   endtask

   task automatic test_div();
      int lat; logic [31:0] res;
      do32(2'd2, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, res); ack32();
      checks++; if (res !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h want 80000000", res); end
      checks++; if (lat != 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
      do32(2'd3, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, res); ack32();
      checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_ovf got %h want 0", res); end
      do32(2'd2, 2'b11, 32'hFFFFFFF9, 32'h2, 1'b0, lat, res); ack32();
      checks++; if (res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg got %h want fffffffd", res); end
      do32(2'd3, 2'b11, 32'hFFFFFFF9, 32'h2, 1'b0, lat, res); ack32();
      checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_neg got %h want ffffffff", res); end
   endtask

   task automatic test_div_zero();
      int lat; logic [31:0] res;
      do32(2'd2, 2'b11, 32'h5, 32'h0, 1'b0, lat, res); ack32();
      checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_result got %h want ffffffff", res); end
      checks++; if (lat != LAT_DZ) begin errors++; $display("FAIL divz_latency got %0d want %0d", lat, LAT_DZ); end
      do32(2'd3, 2'b11, 32'hFFFFFFFB, 32'h0, 1'b0, lat, res); ack32();
      checks++; if (res !== 32'hFFFFFFFB) begin errors++; $display("FAIL remz_result got %h want fffffffb", res); end
      do32(2'd2, 2'b11, 32'h5, 32'h0, 1'b1, lat, res); ack32();
      checks++; if (lat != 34) begin errors++; $display("FAIL divz_fixed_latency got %0d want 34", lat); end
      checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_fixed_result got %h want ffffffff", res); end
   endtask

   task automatic test_kill();
      int seen;
      @(negedge clk);
      if32.req_i = 1; if32.kill_i = 1; if32.operator_i = 2'd2;
      if32.op_a_i = 32'd100; if32.op_b_i = 32'd3; if32.data_ind_timing_i = 1;
      @(posedge clk); #1;
      if32.req_i = 0; if32.kill_i = 0;
      checks++; if (if32.ready_o !== 1'b1) begin errors++; $display("FAIL kill_beats_req got ready %b want 1", if32.ready_o); end
      @(negedge clk); if32.req_i = 1;
      @(posedge clk); #1; if32.req_i = 0;
      repeat (9) begin @(posedge clk); #1; end
      checks++; if (if32.ready_o !== 1'b0) begin errors++; $display("FAIL kill_busy_ready got %b want 0", if32.ready_o); end
      if32.kill_i = 1;
      @(posedge clk); #1; if32.kill_i = 0;
      checks++; if (if32.ready_o !== 1'b1) begin errors++; $display("FAIL kill_ready got %b want 1", if32.ready_o); end
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (if32.valid_o) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL kill_no_valid got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      if32.req_i = 1; if32.operator_i = 2'd0; if32.signed_mode_i = 0;
      if32.op_a_i = 32'd9; if32.op_b_i = 32'd9; if32.data_ind_timing_i = 1;
      @(posedge clk); #1; if32.req_i = 0;
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 0; #2;
      checks++; if (if32.ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", if32.ready_o); end
      checks++; if (if32.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", if32.valid_o); end
      checks++; if (if32.result_o !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", if32.result_o); end
      @(posedge clk); @(negedge clk); rst_n = 1;
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (if32.valid_o) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_valid got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] res;
      do32(2'd0, 2'b00, 32'd3, 32'd5, 1'b1, lat, res);
      checks++; if (res !== 32'd15) begin errors++; $display("FAIL b2b_first got %h want f", res); end
      @(negedge clk);
      if32.ack_i = 1; if32.req_i = 1; if32.operator_i = 2'd0; if32.signed_mode_i = 0;
      if32.op_a_i = 32'd6; if32.op_b_i = 32'd7; if32.data_ind_timing_i = 1;
      @(posedge clk); #1; if32.ack_i = 0;
      checks++; if (if32.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_not_accepted_on_ack got ready %b want 1", if32.ready_o); end
      @(posedge clk); #1; if32.req_i = 0; if32.op_a_i = 0;
      checks++; if (if32.ready_o !== 1'b0) begin errors++; $display("FAIL b2b_accept_next got ready %b want 0", if32.ready_o); end
      lat = 1;
      while (!if32.valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", lat); end
      checks++; if (if32.result_o !== 32'd42) begin errors++; $display("FAIL b2b_second got %h want 2a", if32.result_o); end
      ack32();
   endtask

   task automatic test_w16();
      int lat; logic [15:0] res;
      do16(2'd0, 2'b00, 16'h1234, 16'h0010, 1'b0, lat, res);
      checks++; if (res !== 16'h2340) begin errors++; $display("FAIL w16_mul got %h want 2340", res); end
      checks++; if (lat != LAT16_E) begin errors++; $display("FAIL w16_mul_latency got %0d want %0d", lat, LAT16_E); end
      do16(2'd0, 2'b00, 16'h1234, 16'h0010, 1'b1, lat, res);
      checks++; if (lat != 6) begin errors++; $display("FAIL w16_fixed_latency got %0d want 6", lat); end
      checks++; if (res !== 16'h2340) begin errors++; $display("FAIL w16_fixed_mul got %h want 2340", res); end
      do16(2'd2, 2'b11, 16'h8000, 16'hFFFF, 1'b0, lat, res);
      checks++; if (res !== 16'h8000) begin errors++; $display("FAIL w16_div_ovf got %h want 8000", res); end
      do16(2'd2, 2'b11, 16'hFF9C, 16'h0007, 1'b0, lat, res);
      checks++; if (res !== 16'hFFF2) begin errors++; $display("FAIL w16_div got %h want fff2", res); end
      do16(2'd3, 2'b11, 16'hFF9C, 16'h0007, 1'b0, lat, res);
      checks++; if (res !== 16'hFFFE) begin errors++; $display("FAIL w16_rem got %h want fffe", res); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_div_zero();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      test_w16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
